wam_gen: RTL and testbench

- Mole generator and scorer for the Whac-A-Mole game.
- Consumes the hardness parameters `age` (mole lifetime) and `rto` (spawn likelihood).
- Drives the 16-hole mole bitmap and scores debounced hammer hits.
- Emits `cout0`, a one-cycle carry pulse on every tenth hit, which feeds back into the hardness controller as its automatic "harder" request.

---
 rtl/wam_gen.sv | 103 ++++++++++
 tb/tb_wam_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wam_gen.sv
// Whac-A-Mole mole generator and scorer: LFSR-driven spawns into 16 aging holes,
// with a BCD hit score, a binary miss count and a carry pulse every tenth hit.
module wam_hole (
    input  logic       clk_19,
    input  logic       start,
    input  logic       tick,
    input  logic       hit,
    input  logic       spawn,
    input  logic [3:0] load,
    output logic       mole
);
    logic [3:0] cnt;

    // Hit beats spawn, and spawn beats the tick decrement.
    always_ff @(posedge clk_19) begin
        if (start)                    cnt <= '0;
        else if (hit && cnt != '0)    cnt <= '0;
        else if (spawn)               cnt <= load;
        else if (tick && cnt != '0)   cnt <= cnt - 4'd1;
    end

    assign mole = (cnt != '0);
endmodule

module wam_gen #(
    parameter int          STEP_DIV = 8,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic        clk_19,
    input  logic        start,
    input  logic [3:0]  age,
    input  logic [7:0]  rto,
    input  logic [15:0] hit,
    output logic [15:0] mole,
    output logic [7:0]  score,
    output logic [7:0]  miss,
    output logic        cout0
);
    localparam int NUM_HOLES = 16;
    localparam int DW        = $clog2(STEP_DIV);

    logic [DW-1:0]          div;
    logic [15:0]            lfsr;
    logic                   tick;
    logic                   spawn_ok;
    logic [3:0]             load;
    logic [NUM_HOLES-1:0]   spawn_sel;
    logic                   valid_hit;
    logic                   miss_hit;

    assign tick     = (div == DW'(STEP_DIV - 1));
    assign spawn_ok = tick && (lfsr[7:0] < rto);
    assign load     = (age == 4'd0) ? 4'd1 : age;

    always_comb begin
        spawn_sel = '0;
        spawn_sel[lfsr[11:8]] = spawn_ok;
    end

    always_ff @(posedge clk_19) begin
        if (start) begin
            div  <= '0;
            lfsr <= SEED;
        end else begin
            div  <= tick ? '0 : div + 1'b1;
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    wam_hole u_hole [NUM_HOLES-1:0] (
        .clk_19 (clk_19),
        .start  (start),
        .tick   (tick),
        .hit    (hit),
        .spawn  (spawn_sel),
        .load   (load),
        .mole   (mole)
    );

    // Any number of holes hit in one cycle still scores a single point.
    assign valid_hit = |(hit & mole);
    assign miss_hit  = |(hit & ~mole);

    always_ff @(posedge clk_19) begin
        if (start) begin
            score <= '0;
            miss  <= '0;
            cout0 <= 1'b0;
        end else begin
            cout0 <= 1'b0;
            if (valid_hit && score != 8'h99) begin
                if (score[3:0] == 4'd9) begin
                    score <= {score[7:4] + 4'd1, 4'h0};
                    cout0 <= 1'b1;
                end else begin
                    score[3:0] <= score[3:0] + 4'd1;
                end
            end
            if (miss_hit && miss != 8'hFF)
                miss <= miss + 8'd1;
        end
    end
endmodule

// File: tb/tb_wam_gen.sv
// Bench for wam_gen: a cycle model feeds a scoreboard queue compared every cycle,
// plus a miss-count vector table and directed lifetime / BCD / collision / reset sequences.
module tb_wam_gen;
    localparam int          STEP_DIV = 8;
    localparam logic [15:0] SEED     = 16'hACE1;

    logic        clk_19 = 1'b0;
    logic        start;
    logic [3:0]  age;
    logic [7:0]  rto;
    logic [15:0] hit;
    logic [15:0] mole;
    logic [7:0]  score;
    logic [7:0]  miss;
    logic        cout0;

    int nchecks = 0;
    int nfail   = 0;
    int cout_cnt = 0;

    wam_gen #(.STEP_DIV(STEP_DIV), .SEED(SEED)) dut (
        .clk_19 (clk_19),
        .start  (start),
        .age    (age),
        .rto    (rto),
        .hit    (hit),
        .mole   (mole),
        .score  (score),
        .miss   (miss),
        .cout0  (cout0)
    );

    always #5 clk_19 = ~clk_19;

    typedef struct packed {
        logic [15:0] mole;
        logic [7:0]  score;
        logic [7:0]  miss;
        logic        cout0;
    } obs_t;

    obs_t q[$];

    // Reference model: score kept as a plain integer hit count, converted to BCD on output.
    logic [15:0] m_lfsr;
    int          m_div;
    int          m_cnt[16];
    int          m_hits;
    int          m_miss;
    logic        m_cout;

    always @(posedge clk_19) begin
        logic        tk;
        logic [15:0] mpre;
        logic [3:0]  h;
        obs_t        e;
        if (start) begin
            m_lfsr = SEED;
            m_div  = 0;
            for (int i = 0; i < 16; i++) m_cnt[i] = 0;
            m_hits = 0;
            m_miss = 0;
            m_cout = 1'b0;
        end else begin
            tk = (m_div == STEP_DIV - 1);
            h  = m_lfsr[11:8];
            for (int i = 0; i < 16; i++) mpre[i] = (m_cnt[i] != 0);
            for (int i = 0; i < 16; i++) begin
                if (hit[i] && m_cnt[i] != 0)
                    m_cnt[i] = 0;
                else if (tk && i == int'(h) && m_lfsr[7:0] < rto)
                    m_cnt[i] = (age == 0) ? 1 : int'(age);
                else if (tk && m_cnt[i] != 0)
                    m_cnt[i] = m_cnt[i] - 1;
            end
            m_cout = 1'b0;
            if (|(hit & mpre) && m_hits < 99) begin
                m_hits = m_hits + 1;
                m_cout = (m_hits % 10 == 0);
            end
            if (|(hit & ~mpre) && m_miss < 255) m_miss = m_miss + 1;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            m_div  = tk ? 0 : m_div + 1;
        end
        for (int i = 0; i < 16; i++) e.mole[i] = (m_cnt[i] != 0);
        e.score = 8'((m_hits / 10) * 16 + (m_hits % 10));
        e.miss  = 8'(m_miss);
        e.cout0 = m_cout;
        q.push_back(e);
    end

    always @(negedge clk_19) begin
        obs_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            nchecks++;
            if ({mole, score, miss, cout0} !== e) begin
                nfail++;
                $display("FAIL model t=%0t: got mole=%h score=%h miss=%0d cout0=%b, required mole=%h score=%h miss=%0d cout0=%b",
                         $time, mole, score, miss, cout0, e.mole, e.score, e.miss, e.cout0);
            end
        end
        if (cout0 === 1'b1) cout_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_19);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        hit   = '0;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_mole(input int bound);
        int n = 0;
        while (mole == 16'h0 && n < bound) begin
            step(1);
            n++;
        end
        if (mole == 16'h0) begin
            nchecks++;
            nfail++;
            $display("FAIL wait_mole: mole=%h after %0d cycles, required nonzero", mole, n);
        end
    endtask

    function automatic int lowbit(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Spawn one mole, stop further spawns, and count the cycles it stays visible.
    task automatic lifetime(input logic [3:0] a, output int len);
        int h;
        age = a;
        rto = 8'hFF;
        wait_mole(400);
        rto = 8'h00;
        h   = lowbit(mole);
        len = 1;
        for (int n = 0; n < 300; n++) begin
            step(1);
            if (mole[h]) len++;
            else break;
        end
    endtask

    typedef struct {
        logic [15:0] hit;
        logic [7:0]  exp_miss;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int len;
        int h;
        int found;
        logic all_zero;

        tbl[0] = '{16'h0001, 8'd1};
        tbl[1] = '{16'h0000, 8'd1};
        tbl[2] = '{16'hFFFF, 8'd2};
        tbl[3] = '{16'h8000, 8'd3};
        tbl[4] = '{16'h0000, 8'd3};
        tbl[5] = '{16'h0420, 8'd4};

        start = 1'b1; age = 4'd0; rto = 8'h00; hit = '0;
        step(1);
        start = 1'b0;
        chk("reset_mole", 32'(mole), 32'h0);
        chk("reset_score", 32'(score), 32'h0);
        cout_cnt = 0;

        // Idle with spawns disabled.
        step(1000);
        chk("idle_mole", 32'(mole), 32'h0);
        chk("idle_score", 32'(score), 32'h0);
        chk("idle_miss", 32'(miss), 32'h0);
        chk("idle_cout_pulses", 32'(cout_cnt), 32'h0);

        // Lifetimes.
        lifetime(4'd4, len);
        chk("life_age4", 32'(len), 32'd32);
        lifetime(4'd0, len);
        chk("life_age0", 32'(len), 32'd8);

        // Miss table with no moles present.
        do_reset();
        age = 4'd0; rto = 8'h00;
        for (int i = 0; i < 6; i++) begin
            hit = tbl[i].hit;
            step(1);
            chk($sformatf("tbl%0d_miss", i), 32'(miss), 32'(tbl[i].exp_miss));
            chk($sformatf("tbl%0d_score", i), 32'(score), 32'h0);
        end
        hit = 16'h0001;
        step(300);
        hit = '0;
        chk("miss_sat", 32'(miss), 32'd255);

        // Hit plus miss in the same cycle.
        do_reset();
        age = 4'd15; rto = 8'hFF;
        wait_mole(400);
        rto = 8'h00;
        h   = lowbit(mole);
        hit = 16'((32'h1 << h) | (32'h1 << ((h + 1) % 16)));
        step(1);
        hit = '0;
        chk("hm_mole", 32'(mole[h]), 32'h0);
        chk("hm_score", 32'(score), 32'h01);
        chk("hm_miss", 32'(miss), 32'd1);

        // BCD carry and saturation.
        do_reset();
        cout_cnt = 0;
        age = 4'd15; rto = 8'hFF;
        for (int k = 1; k <= 100; k++) begin
            wait_mole(400);
            hit = mole;
            step(1);
            hit = '0;
            if (k == 10) begin
                chk("bcd10_score", 32'(score), 32'h10);
                chk("bcd10_cout", 32'(cout0), 32'h1);
                step(1);
                chk("bcd10_cout_off", 32'(cout0), 32'h0);
                chk("bcd10_pulses", 32'(cout_cnt), 32'd1);
            end
            if (k == 99) chk("bcd99_score", 32'(score), 32'h99);
            if (k == 100) begin
                chk("sat_score", 32'(score), 32'h99);
                chk("sat_cout", 32'(cout0), 32'h0);
                step(1);
                chk("sat_pulses", 32'(cout_cnt), 32'd9);
                chk("sat_miss", 32'(miss), 32'd0);
            end
        end

        // Hit on the hole that the coming tick would respawn.
        do_reset();
        age = 4'd15; rto = 8'hFF;
        found = 0;
        for (int n = 0; n < 3000 && found == 0; n++) begin
            if (m_div == STEP_DIV - 1 && m_lfsr[7:0] != 8'hFF && m_cnt[m_lfsr[11:8]] != 0) begin
                found = 1;
                h = int'(m_lfsr[11:8]);
                hit = 16'(32'h1 << h);
                step(1);
                hit = '0;
                chk("coll_mole", 32'(mole[h]), 32'h0);
                chk("coll_score", 32'(score), 32'h01);
                chk("coll_miss", 32'(miss), 32'd0);
            end else begin
                step(1);
            end
        end
        chk("coll_found", 32'(found), 32'd1);

        // Reset in the middle of a game at score 37.
        do_reset();
        age = 4'd15; rto = 8'hFF;
        for (int k = 0; k < 37; k++) begin
            wait_mole(400);
            hit = mole;
            step(1);
            hit = '0;
        end
        chk("mid_score", 32'(score), 32'h37);
        wait_mole(400);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("mid_mole", 32'(mole), 32'h0);
        chk("mid_score0", 32'(score), 32'h0);
        chk("mid_cout", 32'(cout0), 32'h0);
        all_zero = 1'b1;
        for (int n = 0; n < STEP_DIV - 1; n++) begin
            step(1);
            if (mole != 16'h0) all_zero = 1'b0;
        end
        chk("mid_first_tick", 32'(all_zero), 32'h1);
        step(20);

        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end
endmodule
